// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path: FSM state encoding,
// parity-select codes and the oversample positions used by the majority voter.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP1,
        RX_STOP2,
        RX_BRKWAIT
    } rx_state_e;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // The three votes straddle the bit centre; the decision is taken on the last one.
    localparam int unsigned OSR_DEFAULT      = 16;
    localparam int unsigned SAMPLE_FIRST_DEF = OSR_DEFAULT / 2 - 1;
    localparam int unsigned SAMPLE_MID_DEF   = OSR_DEFAULT / 2;
    localparam int unsigned SAMPLE_LAST_DEF  = OSR_DEFAULT / 2 + 1;

    function automatic int unsigned sample_tick_first(input int unsigned osr);
        return osr / 2 - 1;
    endfunction

    function automatic int unsigned sample_tick_mid(input int unsigned osr);
        return osr / 2;
    endfunction

    function automatic int unsigned sample_tick_last(input int unsigned osr);
        return osr / 2 + 1;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small first-word-fall-through FIFO; the head entry is presented combinationally
// and reads as zero while the FIFO is empty.
module uart_rx_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             do_push;
    logic             do_pop;

    // A pop frees the slot in the same cycle, so a full FIFO can still accept a push.
    assign do_pop  = pop_i && (level_q != '0);
    assign do_push = push_i && ((level_q != FULL_LVL) || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == FULL_LVL);
    assign level_o = level_q;
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver: input synchroniser, 3-sample majority voter, frame FSM,
// and a receive FIFO carrying per-character framing/parity flags.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DATA_W      = 9,
    parameter int OSR         = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable_i,
    input  logic                            brg_sample_i,
    input  logic [3:0]                      nbits_i,
    input  logic [1:0]                      pdsel_i,
    input  logic                            stop2_i,
    input  logic                            rxd_i,
    input  logic                            pop_i,
    output logic [DATA_W-1:0]               data_o,
    output logic                            ferr_o,
    output logic                            perr_o,
    output logic                            empty_o,
    output logic                            full_o,
    output logic [$clog2(FIFO_DEPTH):0]     level_o,
    output logic                            oerr_o,
    input  logic                            oerr_clr_i,
    output logic                            brk_o,
    output logic                            rts_o
);

    localparam int CW = $clog2(OSR);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = DATA_W + 2;

    localparam logic [CW-1:0] TICK_S0   = CW'(sample_tick_first(OSR));
    localparam logic [CW-1:0] TICK_S1   = CW'(sample_tick_mid(OSR));
    localparam logic [CW-1:0] TICK_DEC  = CW'(sample_tick_last(OSR));
    localparam logic [CW-1:0] TICK_WRAP = CW'(OSR - 1);
    localparam logic [3:0]    NB_MIN    = 4'd5;
    localparam logic [3:0]    NB_MAX    = 4'(DATA_W);
    localparam logic [LW-1:0] RTS_LVL   = LW'(FIFO_DEPTH - 2);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_prev_q;
    logic                   rxs;
    logic [CW-1:0]          cnt_q;
    logic                   s0_q;
    logic                   s1_q;

    rx_state_e              state_q, state_d;
    logic [3:0]             nbits_q, nbits_d;
    logic [1:0]             pdsel_q, pdsel_d;
    logic                   stop2_q, stop2_d;
    logic [3:0]             bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic                   par_q, par_d;
    logic                   ferr_q, ferr_d;
    logic                   brk_q, brk_d;
    logic                   oerr_q;
    logic                   rts_q;

    logic                   tick;
    logic                   start_det;
    logic                   at_dec;
    logic                   at_wrap;
    logic                   bit_val;
    logic                   par_en;
    logic                   perr_calc;
    logic [3:0]             nbits_clamp;
    logic                   frame_push;
    logic [EW-1:0]          frame_entry;
    logic [EW-1:0]          head;

    assign rxs       = sync_q[SYNC_STAGES-1];
    assign tick      = brg_sample_i && enable_i;
    assign start_det = (state_q == RX_IDLE) && enable_i && rx_prev_q && !rxs;
    assign at_dec    = tick && (cnt_q == TICK_DEC);
    assign at_wrap   = tick && (cnt_q == TICK_WRAP);
    assign bit_val   = (s0_q & s1_q) | (s0_q & rxs) | (s1_q & rxs);
    assign par_en    = (pdsel_q == PAR_EVEN) || (pdsel_q == PAR_ODD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '1;
            rx_prev_q <= 1'b1;
            cnt_q     <= '0;
            s0_q      <= 1'b0;
            s1_q      <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], rxd_i};
            rx_prev_q <= rxs;
            if (start_det) begin
                cnt_q <= '0;
            end else if (tick) begin
                cnt_q <= (cnt_q == TICK_WRAP) ? '0 : cnt_q + 1'b1;
            end
            if (tick && (cnt_q == TICK_S0)) begin
                s0_q <= rxs;
            end
            if (tick && (cnt_q == TICK_S1)) begin
                s1_q <= rxs;
            end
        end
    end

    always_comb begin
        nbits_clamp = nbits_i;
        if (nbits_i < NB_MIN) begin
            nbits_clamp = NB_MIN;
        end else if (nbits_i > NB_MAX) begin
            nbits_clamp = NB_MAX;
        end
    end

    // Unused high data bits stay zero, so reducing over the whole register is safe.
    always_comb begin
        perr_calc = 1'b0;
        if (pdsel_q == PAR_EVEN) begin
            perr_calc = (^data_q) ^ par_q;
        end else if (pdsel_q == PAR_ODD) begin
            perr_calc = ~((^data_q) ^ par_q);
        end
    end

    always_comb begin
        state_d    = state_q;
        nbits_d    = nbits_q;
        pdsel_d    = pdsel_q;
        stop2_d    = stop2_q;
        bit_idx_d  = bit_idx_q;
        data_d     = data_q;
        par_d      = par_q;
        ferr_d     = ferr_q;
        brk_d      = 1'b0;
        frame_push = 1'b0;

        case (state_q)
            RX_IDLE: begin
                if (start_det) begin
                    state_d   = RX_START;
                    nbits_d   = nbits_clamp;
                    pdsel_d   = pdsel_i;
                    stop2_d   = stop2_i;
                    bit_idx_d = '0;
                    data_d    = '0;
                    par_d     = 1'b0;
                    ferr_d    = 1'b0;
                end
            end
            RX_START: begin
                if (at_dec && bit_val) begin
                    state_d = RX_IDLE;
                end else if (at_wrap) begin
                    state_d = RX_DATA;
                end
            end
            RX_DATA: begin
                if (at_dec) begin
                    data_d = data_q | (DATA_W'(bit_val) << bit_idx_q);
                end
                if (at_wrap) begin
                    if (bit_idx_q == nbits_q - 4'd1) begin
                        state_d = par_en ? RX_PARITY : RX_STOP1;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
            RX_PARITY: begin
                if (at_dec) begin
                    par_d = bit_val;
                end
                if (at_wrap) begin
                    state_d = RX_STOP1;
                end
            end
            RX_STOP1: begin
                if (at_dec) begin
                    if (!bit_val && (data_q == '0) && (!par_en || !par_q)) begin
                        brk_d   = 1'b1;
                        state_d = RX_BRKWAIT;
                    end else begin
                        ferr_d = !bit_val;
                        if (!stop2_q) begin
                            frame_push = 1'b1;
                            state_d    = RX_IDLE;
                        end
                    end
                end else if (at_wrap && stop2_q) begin
                    state_d = RX_STOP2;
                end
            end
            RX_STOP2: begin
                if (at_dec) begin
                    ferr_d     = ferr_q | !bit_val;
                    frame_push = 1'b1;
                    state_d    = RX_IDLE;
                end
            end
            RX_BRKWAIT: begin
                if (rxs) begin
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase

        if (!enable_i) begin
            state_d    = RX_IDLE;
            frame_push = 1'b0;
            brk_d      = 1'b0;
        end
    end

    assign frame_entry = {ferr_d, perr_calc, data_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RX_IDLE;
            nbits_q   <= '0;
            pdsel_q   <= '0;
            stop2_q   <= 1'b0;
            bit_idx_q <= '0;
            data_q    <= '0;
            par_q     <= 1'b0;
            ferr_q    <= 1'b0;
            brk_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            nbits_q   <= nbits_d;
            pdsel_q   <= pdsel_d;
            stop2_q   <= stop2_d;
            bit_idx_q <= bit_idx_d;
            data_q    <= data_d;
            par_q     <= par_d;
            ferr_q    <= ferr_d;
            brk_q     <= brk_d;
        end
    end

    uart_rx_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (frame_push),
        .pop_i   (pop_i),
        .wdata_i (frame_entry),
        .rdata_o (head),
        .full_o  (full_o),
        .empty_o (empty_o),
        .level_o (level_o)
    );

    // Overrun set takes priority over a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oerr_q <= 1'b0;
            rts_q  <= 1'b1;
        end else begin
            if (frame_push && full_o && !pop_i) begin
                oerr_q <= 1'b1;
            end else if (oerr_clr_i) begin
                oerr_q <= 1'b0;
            end
            rts_q <= (level_o <= RTS_LVL);
        end
    end

    assign data_o = head[DATA_W-1:0];
    assign perr_o = head[DATA_W];
    assign ferr_o = head[DATA_W+1];
    assign oerr_o = oerr_q;
    assign brk_o  = brk_q;
    assign rts_o  = rts_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: serial frames are built from their field values
// and the expected FIFO contents come from a queue-based model of the receive rules.
module tb_uart_rx_core;

    localparam int DATA_W   = 9;
    localparam int OSR      = 16;
    localparam int DEPTH    = 4;
    localparam int SYNC     = 2;
    localparam int TICK_DIV = 4;
    localparam int LW       = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable_i;
    logic              brg_sample_i = 1'b0;
    logic [3:0]        nbits_i;
    logic [1:0]        pdsel_i;
    logic              stop2_i;
    logic              rxd_i;
    logic              pop_i;
    logic [DATA_W-1:0] data_o;
    logic              ferr_o;
    logic              perr_o;
    logic              empty_o;
    logic              full_o;
    logic [LW-1:0]     level_o;
    logic              oerr_o;
    logic              oerr_clr_i;
    logic              brk_o;
    logic              rts_o;

    int compareCount  = 0;
    int mismatchCount = 0;
    int brkCount      = 0;
    int expBrkCount   = 0;
    int divCnt        = 0;

    logic [DATA_W+1:0] modelQ[$];
    bit                modelOerr = 1'b0;

    uart_rx_core #(
        .DATA_W      (DATA_W),
        .OSR         (OSR),
        .FIFO_DEPTH  (DEPTH),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable_i     (enable_i),
        .brg_sample_i (brg_sample_i),
        .nbits_i      (nbits_i),
        .pdsel_i      (pdsel_i),
        .stop2_i      (stop2_i),
        .rxd_i        (rxd_i),
        .pop_i        (pop_i),
        .data_o       (data_o),
        .ferr_o       (ferr_o),
        .perr_o       (perr_o),
        .empty_o      (empty_o),
        .full_o       (full_o),
        .level_o      (level_o),
        .oerr_o       (oerr_o),
        .oerr_clr_i   (oerr_clr_i),
        .brk_o        (brk_o),
        .rts_o        (rts_o)
    );

    always #5 clk = ~clk;

    // Oversample tick: one clock high out of every TICK_DIV, changed away from the sampling edge.
    always @(negedge clk) begin
        divCnt       = (divCnt + 1) % TICK_DIV;
        brg_sample_i = (divCnt == 0);
    end

    always @(posedge clk) begin
        if (brk_o === 1'b1) brkCount++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic checkState(input string tag);
        logic [DATA_W+1:0] head;
        head = (modelQ.size() != 0) ? modelQ[0] : '0;
        checkOutput({tag, ".level"}, 32'(level_o), 32'(modelQ.size()));
        checkOutput({tag, ".empty"}, 32'(empty_o), 32'(modelQ.size() == 0));
        checkOutput({tag, ".full"},  32'(full_o),  32'(modelQ.size() == DEPTH));
        checkOutput({tag, ".rts"},   32'(rts_o),   32'(modelQ.size() <= DEPTH - 2));
        checkOutput({tag, ".oerr"},  32'(oerr_o),  32'(modelOerr));
        checkOutput({tag, ".data"},  32'(data_o),  32'(head[DATA_W-1:0]));
        checkOutput({tag, ".perr"},  32'(perr_o),  32'(head[DATA_W]));
        checkOutput({tag, ".ferr"},  32'(ferr_o),  32'(head[DATA_W+1]));
        checkOutput({tag, ".brk"},   32'(brkCount), 32'(expBrkCount));
    endtask

    task automatic waitTick();
        do @(posedge clk); while (brg_sample_i !== 1'b1);
        #1;
    endtask

    // Reference receive rules: break, framing, parity, then FIFO capacity.
    function automatic void modelFrame(input int data, input logic [1:0] pd, input bit s2,
                                       input bit parBit, input bit stop1Lvl, input bit stop2Lvl);
        bit parEn;
        bit ferr;
        bit perr;
        int ones;
        parEn = (pd == 2'b01) || (pd == 2'b10);
        if (data == 0 && (!parEn || !parBit) && !stop1Lvl) begin
            expBrkCount++;
            return;
        end
        ferr = !stop1Lvl || (s2 && !stop2Lvl);
        ones = $countones(data) + int'(parBit);
        perr = 1'b0;
        if (pd == 2'b01) perr = (ones % 2) != 0;
        if (pd == 2'b10) perr = (ones % 2) == 0;
        if (modelQ.size() == DEPTH) modelOerr = 1'b1;
        else modelQ.push_back({ferr, perr, DATA_W'(data)});
    endfunction

    task automatic applyStimulus(input int nbReq, input logic [1:0] pd, input bit s2, input int dataIn,
                                 input bit flipPar, input bit stop1Lvl, input bit stop2Lvl,
                                 input int spikeSlot, input bit scramble);
        int nb;
        int data;
        bit parEn;
        bit parBit;
        bit lv[$];
        nb     = (nbReq < 5) ? 5 : ((nbReq > DATA_W) ? DATA_W : nbReq);
        data   = dataIn & ((1 << nb) - 1);
        parEn  = (pd == 2'b01) || (pd == 2'b10);
        parBit = ($countones(data) % 2) == 1;
        if (pd == 2'b10) parBit = !parBit;
        parBit = parBit ^ flipPar;
        nbits_i = 4'(nbReq);
        pdsel_i = pd;
        stop2_i = s2;
        lv.push_back(1'b0);
        for (int i = 0; i < nb; i++) lv.push_back(((data >> i) & 1) == 1);
        if (parEn) lv.push_back(parBit);
        lv.push_back(stop1Lvl);
        if (s2) lv.push_back(stop2Lvl);
        waitTick();
        foreach (lv[i]) begin
            rxd_i = lv[i];
            if (i == spikeSlot) begin
                repeat (OSR / 2) waitTick();
                rxd_i = 1'b0;
                waitTick();
                rxd_i = lv[i];
                repeat (OSR / 2 - 1) waitTick();
            end else begin
                repeat (OSR) waitTick();
            end
            if (i == 0 && scramble) begin
                nbits_i = 4'($urandom);
                pdsel_i = 2'($urandom);
                stop2_i = 1'($urandom);
            end
        end
        rxd_i = 1'b1;
        repeat (2) waitTick();
        modelFrame(data, pd, s2, parBit, stop1Lvl, stop2Lvl);
    endtask

    task automatic popEntry(input string tag);
        pop_i = 1'b1;
        @(posedge clk);
        #1;
        pop_i = 1'b0;
        if (modelQ.size() != 0) void'(modelQ.pop_front());
        repeat (2) @(posedge clk);
        #1;
        checkState(tag);
    endtask

    task automatic clearOerr();
        oerr_clr_i = 1'b1;
        @(posedge clk);
        #1;
        oerr_clr_i = 1'b0;
        modelOerr  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        enable_i   = 1'b1;
        rxd_i      = 1'b1;
        pop_i      = 1'b0;
        oerr_clr_i = 1'b0;
        nbits_i    = 4'd8;
        pdsel_i    = 2'b00;
        stop2_i    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkState("reset");
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        applyStimulus(8, 2'b00, 1'b0, 'hA5, 1'b0, 1'b1, 1'b1, -1, 1'b0);
        checkState("8n1");
        popEntry("8n1_pop");

        applyStimulus(7, 2'b01, 1'b1, 'h41, 1'b1, 1'b1, 1'b1, -1, 1'b0);
        checkState("7e2_par");
        popEntry("7e2_par_pop");
        applyStimulus(7, 2'b01, 1'b1, 'h41, 1'b0, 1'b1, 1'b0, -1, 1'b0);
        checkState("7e2_stop");
        popEntry("7e2_stop_pop");

        waitTick();
        rxd_i = 1'b0;
        repeat (6) waitTick();
        rxd_i = 1'b1;
        repeat (2 * OSR) waitTick();
        checkState("glitch");

        applyStimulus(8, 2'b00, 1'b0, 'hFF, 1'b0, 1'b1, 1'b1, 4, 1'b0);
        checkState("spike");
        popEntry("spike_pop");

        for (int v = 1; v <= 5; v++) begin
            applyStimulus(8, 2'b00, 1'b0, v, 1'b0, 1'b1, 1'b1, -1, 1'b0);
            checkState($sformatf("ovr%0d", v));
        end
        clearOerr();
        checkState("ovr_clr");
        for (int i = 0; i < DEPTH; i++) popEntry($sformatf("ovr_pop%0d", i));

        waitTick();
        rxd_i = 1'b0;
        repeat (2 * 10 * OSR) waitTick();
        rxd_i = 1'b1;
        repeat (OSR) waitTick();
        expBrkCount++;
        checkState("break");
        applyStimulus(8, 2'b00, 1'b0, 'h55, 1'b0, 1'b1, 1'b1, -1, 1'b0);
        checkState("after_break");
        popEntry("after_break_pop");

        // Abort a frame partway through its data bits, then receive a clean one.
        nbits_i = 4'd8;
        pdsel_i = 2'b00;
        stop2_i = 1'b0;
        waitTick();
        rxd_i = 1'b0;
        repeat (OSR) waitTick();
        rxd_i = 1'b1;
        repeat (2 * OSR) waitTick();
        enable_i = 1'b0;
        rxd_i = 1'b0;
        repeat (4 * OSR) waitTick();
        rxd_i = 1'b1;
        repeat (3 * OSR) waitTick();
        enable_i = 1'b1;
        repeat (OSR) waitTick();
        checkState("en_drop");
        applyStimulus(8, 2'b00, 1'b0, 'h96, 1'b0, 1'b1, 1'b1, -1, 1'b0);
        checkState("after_en");
        popEntry("after_en_pop");

        for (int n = 0; n < 16; n++) begin
            int  nbReq;
            int  data;
            bit  flip;
            bit  st1;
            bit  st2;
            logic [1:0] pd;
            bit  s2;
            nbReq = $urandom_range(3, 12);
            pd    = 2'($urandom_range(0, 3));
            s2    = 1'($urandom_range(0, 1));
            data  = int'($urandom);
            flip  = ($urandom_range(0, 4) == 0);
            st1   = ($urandom_range(0, 5) != 0);
            st2   = ($urandom_range(0, 5) != 0);
            if ($urandom_range(0, 7) == 0) begin
                data = 0;
                st1  = 1'b0;
                flip = 1'b0;
            end
            applyStimulus(nbReq, pd, s2, data, flip, st1, st2, -1, 1'b1);
            checkState($sformatf("rnd%0d", n));
            for (int p = $urandom_range(0, 2); p > 0; p--) popEntry($sformatf("rnd%0d_pop", n));
            if ($urandom_range(0, 3) == 0) begin
                clearOerr();
                checkState($sformatf("rnd%0d_clr", n));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
